// File: rtl/pipeline_sequencer.sv
// Pipeline control for the MIPS core: per-register enable/flush/bubble, valid tracking, halt latch, perf counters.
// Enables are combinational from ihit/dhit (zero latency); a dcache miss holds every register until dhit.
module pipeline_sequencer #(
    parameter int NREGS      = 4,
    parameter int MEM_REG    = 2,
    parameter int HAZ_REG    = 1,
    parameter int FLUSH_REGS = 2,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             load_use,
    input  logic             redirect,
    input  logic             halt_req,
    output logic             pc_enable,
    output logic [NREGS-1:0] reg_enable,
    output logic [NREGS-1:0] reg_flush,
    output logic [NREGS-1:0] reg_bubble,
    output logic [NREGS-1:0] valid,
    output logic             halt,
    output logic             busy_mem,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    if (MEM_REG >= NREGS) begin : g_bad_mem_reg
        $error("pipeline_sequencer: MEM_REG must be below NREGS");
    end
    if (HAZ_REG >= NREGS) begin : g_bad_haz_reg
        $error("pipeline_sequencer: HAZ_REG must be below NREGS");
    end
    if (FLUSH_REGS > NREGS) begin : g_bad_flush_regs
        $error("pipeline_sequencer: FLUSH_REGS must not exceed NREGS");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t           state;
    logic             live;
    logic             mem_active;
    logic             advance;
    logic             lu_bubble;
    logic [NREGS-1:0] valid_prev;
    logic [NREGS-1:0] valid_next;

    // Gating on nRST keeps every control output quiet while reset is held.
    assign live       = nRST & (state != HALTED);
    assign mem_active = valid[MEM_REG] & mem_req;
    assign advance    = mem_active ? dhit : ihit;
    assign busy_mem   = live & mem_active & ~dhit;
    assign lu_bubble  = live & advance & ~redirect & load_use;

    always_comb begin
        pc_enable  = 1'b0;
        reg_enable = '0;
        reg_flush  = '0;
        reg_bubble = '0;
        if (live && advance) begin
            pc_enable  = 1'b1;
            reg_enable = '1;
            if (redirect) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (i < FLUSH_REGS) reg_flush[i] = 1'b1;
                end
            end else if (load_use) begin
                pc_enable = 1'b0;
                for (int i = 0; i < NREGS; i++) begin
                    if (i < HAZ_REG) reg_enable[i] = 1'b0;
                end
                reg_bubble[HAZ_REG] = 1'b1;
            end
        end
    end

    // Register 0 is always fed a real fetch; the others inherit from upstream.
    always_comb begin
        valid_prev    = valid << 1;
        valid_prev[0] = 1'b1;
        valid_next    = valid_prev & ~reg_flush & ~reg_bubble;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else begin
            valid <= (reg_enable & valid_next) | (~reg_enable & valid);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            halt      <= 1'b0;
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req && valid[MEM_REG] && advance) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (mem_active && !dhit) begin
                        state <= MEMWAIT;
                    end
                end
                MEMWAIT: begin
                    if (halt_req && valid[MEM_REG] && advance) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (advance) begin
                        state <= RUN;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                    halt  <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    halt  <= 1'b0;
                end
            endcase

            if (state != HALTED) begin
                if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_ONE;
                if ((!advance || lu_bubble) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer; expectations are queued by the driver and checked by a negedge monitor.
module tb_pipeline_sequencer;

    logic       CLK;
    logic       nRST;
    logic       ihit, dhit, mem_req, load_use, redirect, halt_req;

    logic       pc_enable, halt, busy_mem;
    logic [3:0] reg_enable, reg_flush, reg_bubble, valid;
    logic [31:0] cycle_cnt, stall_cnt;

    logic       pc_enable4, halt4, busy_mem4;
    logic [3:0] reg_enable4, reg_flush4, reg_bubble4, valid4;
    logic [3:0] cycle_cnt4, stall_cnt4;

    pipeline_sequencer #(.NREGS(4), .MEM_REG(2), .HAZ_REG(1), .FLUSH_REGS(2), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .load_use(load_use), .redirect(redirect), .halt_req(halt_req),
        .pc_enable(pc_enable), .reg_enable(reg_enable), .reg_flush(reg_flush),
        .reg_bubble(reg_bubble), .valid(valid), .halt(halt), .busy_mem(busy_mem),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
    );

    pipeline_sequencer #(.NREGS(4), .MEM_REG(2), .HAZ_REG(1), .FLUSH_REGS(2), .CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .load_use(load_use), .redirect(redirect), .halt_req(halt_req),
        .pc_enable(pc_enable4), .reg_enable(reg_enable4), .reg_flush(reg_flush4),
        .reg_bubble(reg_bubble4), .valid(valid4), .halt(halt4), .busy_mem(busy_mem4),
        .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4)
    );

    localparam int S_PC = 0, S_EN = 1, S_FL = 2, S_BU = 3, S_VA = 4, S_HA = 5,
                   S_BM = 6, S_CY = 7, S_ST = 8, S_ST4 = 9, S_CY4 = 10;

    typedef struct {
        int          id;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        q[$];
    chk_t        mon_c;
    logic [31:0] mon_act;
    int          vectors;
    int          miscompares;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] actual(input int id);
        case (id)
            S_PC:    return 32'(pc_enable);
            S_EN:    return 32'(reg_enable);
            S_FL:    return 32'(reg_flush);
            S_BU:    return 32'(reg_bubble);
            S_VA:    return 32'(valid);
            S_HA:    return 32'(halt);
            S_BM:    return 32'(busy_mem);
            S_CY:    return cycle_cnt;
            S_ST:    return stall_cnt;
            S_ST4:   return 32'(stall_cnt4);
            S_CY4:   return 32'(cycle_cnt4);
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: drains every expectation queued for this cycle at the falling edge.
    initial begin
        vectors     = 0;
        miscompares = 0;
        forever begin
            @(negedge CLK);
            while (q.size() != 0) begin
                mon_c   = q.pop_front();
                mon_act = actual(mon_c.id);
                vectors++;
                if (mon_act !== mon_c.exp) begin
                    miscompares++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", mon_c.name, mon_act, mon_c.exp, $time);
                end
            end
        end
    end

    task automatic check_now(input int id, input logic [31:0] v, input string nm);
        logic [31:0] a;
        #1;
        a = actual(id);
        vectors++;
        if (a !== v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, a, v, $time);
        end
    endtask

    task automatic expect_sig(input int id, input logic [31:0] v, input string nm);
        chk_t c;
        c.id   = id;
        c.exp  = v;
        c.name = nm;
        q.push_back(c);
    endtask

    task automatic drive(input logic i, input logic d, input logic m,
                         input logic lu, input logic rd, input logic hr);
        ihit     = i;
        dhit     = d;
        mem_req  = m;
        load_use = lu;
        redirect = rd;
        halt_req = hr;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] ramp [5];

    initial begin
        ramp[0] = 4'b0000; ramp[1] = 4'b0001; ramp[2] = 4'b0011;
        ramp[3] = 4'b0111; ramp[4] = 4'b1111;

        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        tick;

        // Reset state, with ihit high to show outputs are gated during reset.
        drive(1, 0, 0, 0, 0, 0);
        check_now(S_VA, 0, "rst_valid_now");
        check_now(S_PC, 0, "rst_pc_enable_now");
        expect_sig(S_PC, 0, "rst_pc_enable");
        expect_sig(S_EN, 0, "rst_reg_enable");
        expect_sig(S_VA, 0, "rst_valid");
        expect_sig(S_HA, 0, "rst_halt");
        expect_sig(S_CY, 0, "rst_cycle_cnt");
        expect_sig(S_ST, 0, "rst_stall_cnt");
        tick;
        nRST = 1'b1;

        // Fill: valid ramps in with ihit held.
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            expect_sig(S_PC, 1, "fill_pc_enable");
            expect_sig(S_EN, 4'b1111, "fill_reg_enable");
            expect_sig(S_VA, 32'(ramp[k]), "fill_valid");
            tick;
        end
        expect_sig(S_VA, 4'b1111, "fill_valid_full");
        expect_sig(S_CY, 5, "fill_cycle_cnt");
        expect_sig(S_ST, 0, "fill_stall_cnt");

        // Dcache miss for three cycles, then hit.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 0, 0);
            check_now(S_BM, 1, "miss_busy_mem_now");
            check_now(S_EN, 0, "miss_reg_enable_now");
            expect_sig(S_BM, 1, "miss_busy_mem");
            expect_sig(S_EN, 0, "miss_reg_enable");
            expect_sig(S_PC, 0, "miss_pc_enable");
            tick;
        end
        drive(1, 1, 1, 0, 0, 0);
        check_now(S_EN, 4'b1111, "dhit_reg_enable_now");
        expect_sig(S_BM, 0, "dhit_busy_mem");
        expect_sig(S_EN, 4'b1111, "dhit_reg_enable");
        expect_sig(S_PC, 1, "dhit_pc_enable");
        tick;
        expect_sig(S_ST, 3, "miss_stall_cnt");
        expect_sig(S_CY, 9, "miss_cycle_cnt");
        expect_sig(S_VA, 4'b1111, "miss_valid");

        // Load-use bubble.
        drive(1, 0, 0, 1, 0, 0);
        expect_sig(S_PC, 0, "lu_pc_enable");
        expect_sig(S_EN, 4'b1110, "lu_reg_enable");
        expect_sig(S_BU, 4'b0010, "lu_reg_bubble");
        expect_sig(S_FL, 0, "lu_reg_flush");
        tick;
        expect_sig(S_VA, 4'b1101, "lu_valid");
        expect_sig(S_ST, 4, "lu_stall_cnt");

        // Redirect overrides load-use.
        drive(1, 0, 0, 1, 1, 0);
        expect_sig(S_FL, 4'b0011, "rd_reg_flush");
        expect_sig(S_EN, 4'b1111, "rd_reg_enable");
        expect_sig(S_BU, 0, "rd_reg_bubble");
        expect_sig(S_PC, 1, "rd_pc_enable");
        tick;
        expect_sig(S_VA, 4'b1000, "rd_valid");
        expect_sig(S_ST, 4, "rd_stall_cnt");

        // Refill until the MEM register is valid, then halt.
        drive(1, 0, 0, 0, 0, 0);
        expect_sig(S_VA, 4'b1000, "refill_valid0");
        tick;
        expect_sig(S_VA, 4'b0001, "refill_valid1");
        tick;
        expect_sig(S_VA, 4'b0011, "refill_valid2");
        tick;
        drive(1, 0, 0, 0, 0, 1);
        expect_sig(S_VA, 4'b0111, "halt_req_valid");
        expect_sig(S_EN, 4'b1111, "halt_req_reg_enable");
        expect_sig(S_HA, 0, "halt_req_halt");
        tick;
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 0, 0, 1'(k % 2), 0);
            expect_sig(S_HA, 1, "halted_halt");
            expect_sig(S_PC, 0, "halted_pc_enable");
            expect_sig(S_EN, 0, "halted_reg_enable");
            expect_sig(S_FL, 0, "halted_reg_flush");
            expect_sig(S_VA, 4'b1111, "halted_valid");
            expect_sig(S_CY, 15, "halted_cycle_cnt");
            expect_sig(S_ST, 4, "halted_stall_cnt");
            tick;
        end

        // Reset out of HALTED, refill, enter MEMWAIT and reset again mid-wait.
        nRST = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        expect_sig(S_HA, 0, "rst2_halt");
        expect_sig(S_VA, 0, "rst2_valid");
        expect_sig(S_PC, 0, "rst2_pc_enable");
        expect_sig(S_CY, 0, "rst2_cycle_cnt");
        tick;
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) tick;
        drive(1, 0, 1, 0, 0, 0);
        expect_sig(S_VA, 4'b0111, "mw_valid");
        expect_sig(S_BM, 1, "mw_busy_mem0");
        tick;
        expect_sig(S_BM, 1, "mw_busy_mem1");
        expect_sig(S_EN, 0, "mw_reg_enable");
        tick;
        nRST = 1'b0;
        expect_sig(S_VA, 0, "rst3_valid");
        expect_sig(S_HA, 0, "rst3_halt");
        expect_sig(S_BM, 0, "rst3_busy_mem");
        expect_sig(S_EN, 0, "rst3_reg_enable");
        expect_sig(S_ST4, 0, "rst3_stall_cnt4");
        tick;
        nRST = 1'b1;
        expect_sig(S_EN, 4'b1111, "post_rst_reg_enable");
        expect_sig(S_PC, 1, "post_rst_pc_enable");
        expect_sig(S_BM, 0, "post_rst_busy_mem");
        expect_sig(S_VA, 0, "post_rst_valid");
        tick;

        // Twenty stalled cycles: the 4-bit counter must pin at 15.
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            expect_sig(S_ST, 32'(k), "stall_cnt32");
            expect_sig(S_ST4, (k > 15) ? 32'd15 : 32'(k), "stall_cnt4");
            tick;
        end
        expect_sig(S_ST, 20, "final_stall_cnt");
        expect_sig(S_ST4, 15, "final_stall_cnt4");
        expect_sig(S_CY, 21, "final_cycle_cnt");
        expect_sig(S_CY4, 15, "final_cycle_cnt4");
        @(negedge CLK);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Parametrised pipeline control block for the pipelined MIPS core.
- Centralises the per-register enable, flush and bubble generation that the datapath currently builds ad hoc from ihit/dhit, load-use and branch/jump flush.
- Tracks a valid bit per pipeline register and runs the halt drain/latch.
- Generalised to any number of pipeline registers, with configurable memory-stage, hazard-stage and flush depth, plus saturating performance counters.

Parameters:
NREGS, 4, number of pipeline registers (index 0 = IF/ID ... NREGS-1 = MEM/WB)
MEM_REG, 2, index of register whose outputs drive the dcache request (EX/MEM)
HAZ_REG, 1, register that receives a bubble on load-use stall (ID/EX); registers below it and the PC hold
FLUSH_REGS, 2, registers 0..FLUSH_REGS-1 are flushed on redirect
CNT_W, 32, performance counter width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous reset, active low
ihit  in  1  icache hit this cycle
dhit  in  1  dcache hit this cycle
mem_req  in  1  register MEM_REG holds a dREN or dWEN instruction
load_use  in  1  hazard unit load-use stall request
redirect  in  1  taken branch or jump resolved this cycle
halt_req  in  1  halt instruction present in register MEM_REG
pc_enable  out  1  PC update enable
reg_enable  out  NREGS  per-register load enable
reg_flush  out  NREGS  per-register synchronous clear
reg_bubble  out  NREGS  per-register "load NOP" (WEN/dWEN/instr zeroed)
valid  out  NREGS  register holds a real instruction
halt  out  1  sticky halt to cache/system
busy_mem  out  1  stalled waiting on dcache
cycle_cnt  out  CNT_W  cycles since reset, not incremented while halted
stall_cnt  out  CNT_W  cycles with advance=0 or load_use bubble, while not halted

Behaviour:
- Reset (async, nRST=0): state RUN; valid=0; halt=0; counters=0. All enable, flush and bubble outputs are 0 while nRST=0.
- mem_active = valid[MEM_REG] & mem_req.
- advance = mem_active ? dhit : ihit. This is combinational, with no added latency.

State machine:
- RUN:
  - mem_active & !dhit -> MEMWAIT.
  - halt_req & valid[MEM_REG] & advance -> HALTED at next edge.
- MEMWAIT:
  - busy_mem=1; all enables 0.
  - dhit -> RUN. This same cycle advances normally (enables asserted).
  - halt_req & dhit -> HALTED.
- HALTED:
  - Absorbing until reset.
  - halt=1; pc_enable, reg_enable, reg_flush and reg_bubble all 0; valid frozen; counters frozen.

Outputs in RUN/MEMWAIT when advance=1 (priority order):
1. redirect:
   - reg_flush[i]=1 for i<FLUSH_REGS.
   - reg_enable all 1; pc_enable=1.
   - Overrides load_use.
2. load_use:
   - pc_enable=0; reg_enable[i]=0 for i<HAZ_REG.
   - reg_enable[i]=1 for i>=HAZ_REG; reg_bubble[HAZ_REG]=1.
3. Otherwise: pc_enable=1; all reg_enable=1.
- When advance=0: all enables, flushes and bubbles are 0.

Valid update, on edge with the register enabled:
- valid[0] <= ~flush[0].
- valid[i] <= valid[i-1] & ~flush[i] & ~bubble[i].
- Held registers keep their value.

Halt:
- halt asserts the cycle after the halt-carrying MEM register advances.
- Registers beyond MEM_REG are not drained further.

Counters:
- Saturate at all-ones; no wrap.
- stall_cnt increments when (advance=0 | load_use-bubble cycle) and state!=HALTED.

Reset mid-operation (any state, including MEMWAIT): immediate return to reset values.

Elaboration checks: MEM_REG<NREGS, HAZ_REG<NREGS, FLUSH_REGS<=NREGS; otherwise elaboration error.

Test Plan:
1. Reset, then ihit=1 for 5 cycles with no hazards -> valid ramps 0001,0011,0111,1111; pc_enable=1 each cycle; cycle_cnt=5, stall_cnt=0.
2. Pipe full, mem_req=1, dhit=0 for 3 cycles then 1 -> busy_mem=1 and enables=0 for 3 cycles; enables=1111 on the dhit cycle; stall_cnt=3.
3. load_use=1 one cycle with ihit=1 -> pc_enable=0, reg_enable=1110, reg_bubble=0010; next cycle valid[1]=0, valid[0] unchanged.
4. redirect=1 and load_use=1 together, ihit=1 -> reg_flush=0011, reg_enable=1111, reg_bubble=0000, pc_enable=1; valid[1:0]=00 next cycle.
5. halt_req=1 with valid[2]=1 and advance -> halt=1 next cycle and stays 1 for 20 cycles; cycle_cnt frozen; all enables 0 regardless of ihit/redirect.
6. nRST pulsed low mid-MEMWAIT; also CNT_W=4 with 20 stalled cycles -> state RUN, valid=0, halt=0 after reset; stall_cnt saturates at 15.
